// File: rtl/prefix_counter.sv
// prefix_counter: loadable up/down counter whose carry/borrow chain is a prefix-AND tree.
// Define LAU_COUNTER_SATURATE_EN to make enabled steps at terminal count hold instead of wrap.
package lau_pkg;
    typedef enum logic [1:0] {SLOW, MEDIUM, FAST} speed_e;
endpackage

module prefix_and #(
    parameter int              width = 8,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic [width-1:0] pi_i,
    output logic [width-1:0] po_o
);
    localparam int L = $clog2(width);
    localparam int N = (speed == lau_pkg::MEDIUM) ? 2 * L : L;
    genvar s, i;
    if (speed == lau_pkg::SLOW || N == 0) begin : g_serial
        for (i = 0; i < width; i++) begin : g_c
            logic c;
            if (i == 0) begin : g_first
                assign c = pi_i[0];
            end else begin : g_next
                assign c = g_c[i-1].c & pi_i[i];
            end
            assign po_o[i] = c;
        end
    end else begin : g_tree
        // MEDIUM: Brent-Kung up-sweep then down-sweep; FAST: Sklansky doubling stages
        for (s = 0; s < N; s++) begin : g_s
            localparam int lv = (s < L) ? s : 2 * L - 1 - s;
            localparam int st = 1 << lv;
            logic [width-1:0] a, b;
            if (s == 0) begin : g_in
                assign a = pi_i;
            end else begin : g_prev
                assign a = g_s[s-1].b;
            end
            for (i = 0; i < width; i++) begin : g_b
                localparam bit hit = (speed == lau_pkg::FAST) ? (((i >> lv) & 1) == 1)
                                   : (s < L) ? ((i + 1) % (2 * st) == 0)
                                   : (i >= 3 * st - 1 && (i + 1 - st) % (2 * st) == 0);
                localparam int src = (speed == lau_pkg::FAST) ? ((i >> lv) << lv) - 1 : i - st;
                if (hit) begin : g_and
                    assign b[i] = a[i] & a[src];
                end else begin : g_pass
                    assign b[i] = a[i];
                end
            end
        end
        assign po_o = g_s[N-1].b;
    end
endmodule

module prefix_counter #(
    parameter int              width = 8,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [width-1:0] load_val_i,
    input  logic             en_i,
    input  logic             down_i,
    output logic [width-1:0] cnt_o,
    output logic             tc_o,
    output logic             ovf_o
);
    logic [width-1:0] cnt_q, cnt_d, pi, po, t, step;
    logic             ovf_q, ovf_d;
    assign pi = down_i ? ~cnt_q : cnt_q;
    prefix_and #(.width(width), .speed(speed)) u_prefix (
        .pi_i(pi),
        .po_o(po)
    );
    assign t    = (po << 1) | width'(1'b1);
    assign tc_o = po[width-1];
`ifdef LAU_COUNTER_SATURATE_EN
    assign step = tc_o ? cnt_q : cnt_q ^ t;
`else
    assign step = cnt_q ^ t;
`endif
    always_comb begin
        cnt_d = clr_i ? '0 : load_i ? load_val_i : en_i ? step : cnt_q;
        ovf_d = !clr_i && !load_i && en_i && tc_o;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;
endmodule

// File: tb/tb_prefix_counter.sv
// tb_prefix_counter: directed checks of prefix_counter across all three prefix speeds plus width 1.
// Expectations follow LAU_COUNTER_SATURATE_EN when it is defined.
module tb_prefix_counter;
    import lau_pkg::*;
`ifdef LAU_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic       clk_i = 1'b0, rst_ni = 1'b0, clr_i = 1'b0, load_i = 1'b0, en_i = 1'b0, down_i = 1'b0;
    logic [7:0] load_val_i = '0;
    logic [7:0] cnt [3];
    logic       tc  [3];
    logic       ovf [3];
    logic       cnt1, tc1, ovf1;
    logic [7:0] exp_cnt = '0;
    int         n_chk = 0, n_pass = 0;

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        prefix_counter #(.width(8), .speed(speed_e'(g))) u_dut (
            .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .load_i(load_i),
            .load_val_i(load_val_i), .en_i(en_i), .down_i(down_i),
            .cnt_o(cnt[g]), .tc_o(tc[g]), .ovf_o(ovf[g])
        );
    end

    prefix_counter #(.width(1), .speed(FAST)) u_w1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .load_i(load_i),
        .load_val_i(load_val_i[0]), .en_i(en_i), .down_i(down_i),
        .cnt_o(cnt1), .tc_o(tc1), .ovf_o(ovf1)
    );

    function automatic logic [7:0] nxt(logic [7:0] v, logic d);
        logic at_tc;
        at_tc = d ? (v == 8'h00) : (v == 8'hFF);
        if (SAT && at_tc) return v;
        return d ? v - 8'd1 : v + 8'd1;
    endfunction

    task automatic check(string tag, logic [7:0] e, logic e_ovf);
        logic e_tc;
        e_tc = down_i ? (e == 8'h00) : (e == 8'hFF);
        for (int g = 0; g < 3; g++) begin
            n_chk++;
            assert (cnt[g] === e) n_pass++;
            else $error("FAIL %s cnt[%0d]: got %h expected %h", tag, g, cnt[g], e);
            n_chk++;
            assert (tc[g] === e_tc) n_pass++;
            else $error("FAIL %s tc[%0d]: got %b expected %b", tag, g, tc[g], e_tc);
            n_chk++;
            assert (ovf[g] === e_ovf) n_pass++;
            else $error("FAIL %s ovf[%0d]: got %b expected %b", tag, g, ovf[g], e_ovf);
        end
`ifndef LAU_COUNTER_SATURATE_EN
        n_chk++;
        assert (cnt1 === e[0]) n_pass++;
        else $error("FAIL %s w1 cnt: got %b expected %b", tag, cnt1, e[0]);
        n_chk++;
        assert (tc1 === (e[0] ^ down_i)) n_pass++;
        else $error("FAIL %s w1 tc: got %b expected %b", tag, tc1, e[0] ^ down_i);
`endif
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load(string tag, logic [7:0] v);
        load_i = 1'b1;
        load_val_i = v;
        step();
        load_i = 1'b0;
        exp_cnt = v;
        check(tag, v, 1'b0);
    endtask

    task automatic run(string tag, logic d, int n);
        logic tcb;
        down_i = d;
        en_i = 1'b1;
        repeat (n) begin
            tcb = d ? (exp_cnt == 8'h00) : (exp_cnt == 8'hFF);
            exp_cnt = nxt(exp_cnt, d);
            step();
            check(tag, exp_cnt, tcb);
        end
    endtask

    initial begin
        logic [7:0] vals [10] = '{8'h00, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'h80, 8'hAA, 8'hFF};
        en_i = 1'b1;
        step();
        step();
        check("reset", 8'h00, 1'b0);
        rst_ni = 1'b1;
        en_i = 1'b0;
        repeat (3) begin
            step();
            check("hold_after_reset", 8'h00, 1'b0);
        end
        load("load_fd", 8'hFD);
        run("up_wrap", 1'b0, 4);
        load("load_02", 8'h02);
        run("down_wrap", 1'b1, 4);
        for (int v = 0; v < 10; v++) begin
            for (int d = 0; d < 2; d++) begin
                en_i = 1'b0;
                load("carry_load", vals[v]);
                run("carry_step", d[0], 1);
            end
        end
        en_i = 1'b0;
        load("dir_load", 8'h10);
        run("dir_up", 1'b0, 1);
        run("dir_down", 1'b1, 1);
        en_i = 1'b0;
        down_i = 1'b0;
        load("prio_load", 8'h55);
        clr_i = 1'b1;
        load_i = 1'b1;
        en_i = 1'b1;
        load_val_i = 8'hAA;
        step();
        check("prio_clr", 8'h00, 1'b0);
        clr_i = 1'b0;
        step();
        load_i = 1'b0;
        check("prio_load_over_en", 8'hAA, 1'b0);
        en_i = 1'b0;
        load("tc_load", 8'hFF);
        load_i = 1'b1;
        en_i = 1'b1;
        load_val_i = 8'h10;
        step();
        load_i = 1'b0;
        check("load_at_tc", 8'h10, 1'b0);
        load("tc_load2", 8'hFF);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        check("clr_at_tc", 8'h00, 1'b0);
        en_i = 1'b0;
        load("hold_load", 8'hFF);
        step();
        check("hold_at_tc", 8'hFF, 1'b0);
        down_i = 1'b1;
        #1;
        check("tc_follows_down", 8'hFF, 1'b0);
        down_i = 1'b0;
        load("sat_load", 8'hFF);
        run("sat_up", 1'b0, 3);
        en_i = 1'b0;
        load("async_load", 8'h5A);
        en_i = 1'b1;
        #3;
        rst_ni = 1'b0;
        #1;
        exp_cnt = 8'h00;
        check("async_reset", 8'h00, 1'b0);
        step();
        check("held_in_reset", 8'h00, 1'b0);
        rst_ni = 1'b1;
        run("post_reset", 1'b0, 2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
